wb_stage_seq: RTL
=================

Name: wb_stage_seq

Overview:
- Parametrised, registered writeback stage for the SPARC pipeline. Sits between MEM and the register file.
- Selects load data or ALU result per instruction. Suppresses NOPs (sethi 0,%g0) and writes to %g0.
- Sequences double-word writes (ldd-class, regWriteDouble) into two single-register writes on consecutive cycles, with valid/ready backpressure toward MEM.

Parameters:
- XLEN, 32, architectural register width; data inputs are 2*XLEN wide.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage accepts this cycle
- alures_in  in  2*XLEN  ALU result
- load_data_in  in  2*XLEN  load data
- regD_in  in  RADDR_W  destination register
- op_in  in  2  SPARC op field
- op2_in  in  3  SPARC op2 field
- op3_in  in  6  SPARC op3 field (carried through; not decoded here)
- regWrite_in  in  1  single-register write request
- regWriteDouble_in  in  1  register-pair write request
- rf_we  out  1  register-file write enable
- rf_waddr  out  RADDR_W  write address
- rf_wdata  out  XLEN  write data
- align_err  out  1  one-cycle pulse: double write with odd regD_in

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Handshake: an instruction is accepted when in_valid && in_ready.
- Latency: the first write appears on the rf_* outputs in the cycle after acceptance. All rf_* outputs are registered.
- Data select: sel = (op_in==2'b11) ? load_data_in : alures_in.
- Single write: rf_wdata = sel[XLEN-1:0].
- NOP: op_in==00 && op2_in==100 && regD_in==0. The NOP is accepted, produces no write, and consumes no extra cycle.
- %g0: any individual write whose address is 0 is dropped (rf_we=0). The other half of a pair is unaffected.
- Priority: if regWriteDouble_in is set, it takes priority over regWrite_in. If neither is set, the instruction is accepted with no write.
- Double write address: base = {regD_in[RADDR_W-1:1],1'b0}.
  - First write: base with sel[2*XLEN-1:XLEN].
  - Second write: base+1 with sel[XLEN-1:0].
- Odd regD_in on a double: the address is forced even as above, and align_err pulses in the same cycle as the first write.
- FSM states:
  - IDLE: no write pending.
  - W1: first or single write presented on the outputs.
  - W2: second half of a pair presented.
- FSM transitions:
  - IDLE --accept(write or double)--> W1.
  - IDLE --accept(NOP or no-write)--> IDLE.
  - W1 (single) --accept--> W1 or IDLE according to the new instruction; back-to-back singles run at full throughput.
  - W1 (double) --> W2 unconditionally.
  - W2 --accept--> W1 or IDLE.
- in_ready = !(state==W1 && pair_pending). Exactly one bubble is inserted per double write.
- in_valid low: no accept; the stage returns to IDLE after the current write completes.
- Reset values: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, align_err=0. in_ready is 1 out of reset.
- Reset asserted in W1/W2: the pending second write is discarded. rf_we=0 in the cycle after reset.
- Inputs are ignored when not accepted. Second-half data is latched at acceptance and is not resampled.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- When defined:
  - Adds output retire_cnt [31:0]: increments by 1 per accepted non-NOP instruction.
  - Adds output nop_cnt [31:0]: increments per accepted NOP.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
  - A double-word instruction counts once.
- When undefined: neither port exists and the logic is identical otherwise.

Decomposition:
- Shared package sparc_wb_pkg:
  - wb_state_e enum (IDLE, W1, W2).
  - Constants OP_LOAD=2'b11, OP_BRSETHI=2'b00, OP2_SETHI=3'b100, REG_G0=0.
  - Function is_nop(op, op2, rd).
- One sub-module, wb_pair_splitter: takes the latched 2*XLEN word, base address and double flag, and produces the per-cycle address/data for W1/W2 including %g0 suppression.

Test Plan:
- ALU single write: op=10, regD=5, alures=0x0000_0000_DEAD_BEEF, regWrite=1 -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; in_ready stays 1.
- Load double: op=11, regD=8, load_data=0x1111_2222_3333_4444, regWriteDouble=1 -> cycle+1: waddr=8, wdata=0x11112222; cycle+2: waddr=9, wdata=0x33334444; in_ready=0 exactly in cycle+1.
- NOP and %g0: sethi 0,%g0 -> rf_we=0, no stall. ALU write to rd=0 -> rf_we=0. Double with rd=0 -> only waddr=1 is written, with the low word.
- Odd double: regD=7, regWriteDouble=1 -> writes to 6 and 7, align_err=1 only in the first-write cycle.
- Back-to-back: four consecutive valid single writes -> four consecutive rf_we cycles with correct addresses. Reset asserted during W2 of a double -> the second write is never issued and all outputs are 0 next cycle.
- WB_PERF_CNT_EN: 3 singles, 1 double, 2 NOPs -> retire_cnt=4, nop_cnt=2. Preloaded 0xFFFFFFFF + 1 retire -> retire_cnt=0.

Source files
------------

// File: rtl/sparc_wb_pkg.sv
// Shared types and constants for the SPARC writeback stage.
// Decode helpers used by wb_stage_seq and wb_pair_splitter.
package sparc_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2
  } wb_state_e;

  localparam logic [1:0]  OP_LOAD    = 2'b11;
  localparam logic [1:0]  OP_BRSETHI = 2'b00;
  localparam logic [2:0]  OP2_SETHI  = 3'b100;
  localparam int unsigned REG_G0     = 0;

  // sethi 0,%g0 is the canonical NOP; rd is passed zero-extended to 32 bits.
  function automatic logic is_nop(input logic [1:0] op, input logic [2:0] op2,
                                  input logic [31:0] rd);
    return (op == OP_BRSETHI) && (op2 == OP2_SETHI) && (rd == REG_G0);
  endfunction

endpackage

// File: rtl/wb_pair_splitter.sv
// Produces the address/data/enable for one register-file write: the single or
// first half (high word for pairs) or the second half (base+1, low word).
module wb_pair_splitter
  import sparc_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [2*XLEN-1:0]  word,
  input  logic [RADDR_W-1:0] base,
  input  logic               is_double,
  input  logic               second,
  input  logic               write,
  output logic               we,
  output logic [RADDR_W-1:0] addr,
  output logic [XLEN-1:0]    data
);

  always_comb begin
    addr = base;
    data = word[XLEN-1:0];
    if (second) begin
      addr = {base[RADDR_W-1:1], 1'b1};
    end else if (is_double) begin
      data = word[2*XLEN-1:XLEN];
    end
    // %g0 is hardwired zero: each half is dropped independently.
    we = write && (addr != RADDR_W'(REG_G0));
  end

endmodule

// File: rtl/wb_stage_seq.sv
// Registered SPARC writeback stage: selects load/ALU data, drops NOPs and %g0
// writes, splits pair writes over two cycles. Optional counters: WB_PERF_CNT_EN.
module wb_stage_seq
  import sparc_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*XLEN-1:0]  alures_in,
  input  logic [2*XLEN-1:0]  load_data_in,
  input  logic [RADDR_W-1:0] regD_in,
  input  logic [1:0]         op_in,
  input  logic [2:0]         op2_in,
  input  logic [5:0]         op3_in,
  input  logic               regWrite_in,
  input  logic               regWriteDouble_in,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               align_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]        retire_cnt,
  output logic [31:0]        nop_cnt
`endif
);

  wb_state_e state_reg, state_next;

  logic [2*XLEN-1:0]  word_reg;
  logic [RADDR_W-1:0] base_reg;
  logic               pair_reg;

  logic               accept;
  logic               nop;
  logic               do_double;
  logic               do_write;
  logic [2*XLEN-1:0]  sel;
  logic [RADDR_W-1:0] first_addr;

  logic               split_second;
  logic [2*XLEN-1:0]  split_word;
  logic [RADDR_W-1:0] split_base;
  logic               split_double;
  logic               split_write;
  logic               split_we;
  logic [RADDR_W-1:0] split_addr;
  logic [XLEN-1:0]    split_data;

  // op3 travels with the instruction but is not decoded in this stage.
  logic unused_op3;
  assign unused_op3 = ^op3_in;

  always_comb begin
    sel        = (op_in == OP_LOAD) ? load_data_in : alures_in;
    nop        = is_nop(op_in, op2_in, 32'(regD_in));
    in_ready   = !((state_reg == W1) && pair_reg);
    accept     = in_valid && in_ready;
    do_double  = !nop && regWriteDouble_in;
    do_write   = !nop && (regWriteDouble_in || regWrite_in);
    first_addr = do_double ? {regD_in[RADDR_W-1:1], 1'b0} : regD_in;

    // While the second half is owed, the splitter works from latched state only.
    split_second = !in_ready;
    split_word   = split_second ? word_reg : sel;
    split_base   = split_second ? base_reg : first_addr;
    split_double = split_second ? 1'b1     : do_double;
    split_write  = split_second ? 1'b1     : (accept && do_write);
  end

  always_comb begin
    state_next = IDLE;
    unique case (state_reg)
      W1: begin
        if (pair_reg)                state_next = W2;
        else if (accept && do_write) state_next = W1;
      end
      IDLE, W2: begin
        if (accept && do_write)      state_next = W1;
      end
      default: state_next = IDLE;
    endcase
  end

  wb_pair_splitter #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) u_splitter (
    .word      (split_word),
    .base      (split_base),
    .is_double (split_double),
    .second    (split_second),
    .write     (split_write),
    .we        (split_we),
    .addr      (split_addr),
    .data      (split_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      base_reg  <= '0;
      pair_reg  <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      align_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      pair_reg  <= in_ready && accept && do_double;
      if (accept) begin
        word_reg <= sel;
        base_reg <= first_addr;
      end
      rf_we     <= split_we;
      if (split_we) begin
        rf_waddr <= split_addr;
        rf_wdata <= split_data;
      end
      align_err <= accept && do_double && regD_in[0];
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      nop_cnt    <= '0;
    end else if (accept) begin
      if (nop) nop_cnt    <= nop_cnt + 32'd1;
      else     retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
